keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Autonomous 4x4 matrix keypad scanner for the PicoBlaze I/O subsystem.
- Drives one column low at a time and samples the active-low rows through a synchronizer.
- Debounces whole-matrix scan results and pushes one key code per debounced press into a small FIFO.
- The PicoBlaze read side follows the UART receive convention: `data_present` flag, head data, one-cycle read acknowledge. It replaces the ad-hoc `up_counter`/`keyflag` logic on input port 06.

Parameters:
- SCAN_DIV, 100000: clk cycles each column is driven (1 ms at 100 MHz); minimum 4.
- DEBOUNCE_SCANS, 4: consecutive identical full scans needed to accept a press, and also to accept a release; minimum 1.
- FIFO_DEPTH, 4: key event FIFO entries; power of two.

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  Synchronous, active-low reset.
- col  out  4  Column drive, one-hot-low (0 = column driven).
- row  in  4  Row sense, active-low, externally pulled up, asynchronous to clk.
- key_code  out  8  FIFO head: {4'h0, col_idx[1:0], row_idx[1:0]}.
- key_present  out  1  FIFO not empty.
- read_key_ack  in  1  One-cycle pulse that pops the FIFO head.
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
- overflow  out  1  Sticky: a debounced press was dropped because the FIFO was full.

Behaviour:
- Reset (reset==0 at posedge clk):
  - col=4'b1110, col_idx=0, divider=0.
  - FSM=IDLE, FIFO empty.
  - key_code=0, key_present=0, fifo_full=0, overflow=0.
  - Synchronizer flops=4'hF.
- Synchronizer: row passes through 2 flops (row_s) before any use.
- Column scan:
  - The divider counts 0..SCAN_DIV-1.
  - On the terminal count, row_s is sampled for the current column, then col_idx increments mod 4.
  - col = ~(4'b0001 << col_idx), registered.
- Scan result:
  - Accumulated over col_idx 0..3.
  - The first low row_s bit wins: lowest col_idx, then lowest row_idx.
  - Multi-key presses report only the winner; no ghost rejection.
  - A scan completes at the terminal count of col_idx 3, yielding either key k or NONE.
- Debounce FSM, evaluated once per completed scan:
  - IDLE:
    - k seen -> CAND (cand=k, cnt=1); if DEBOUNCE_SCANS==1, push k and go to HELD immediately.
    - NONE -> stay IDLE.
  - CAND:
    - scan==cand -> cnt+1; when cnt reaches DEBOUNCE_SCANS, push cand and go to HELD.
    - different key -> cand=new key, cnt=1.
    - NONE -> IDLE.
  - HELD:
    - scan==cand -> rcnt=0.
    - anything else -> rcnt+1; when rcnt reaches DEBOUNCE_SCANS -> IDLE.
    - No auto-repeat. A second key pressed while the first is held is not reported until the FSM has passed through IDLE.
- Push latency: at most (DEBOUNCE_SCANS+1) scans from a stable press, plus 2 sync cycles. key_present rises the cycle after the push.
- FIFO:
  - Show-ahead: key_code is valid whenever key_present==1, and is 0 when empty.
  - read_key_ack pops on the clk edge where it is high.
  - Ack while empty is ignored.
  - Push while full (without a simultaneous pop): entry dropped, overflow<=1.
  - Push and pop in the same cycle while full: both succeed, overflow unchanged.
  - Push and pop in the same cycle while empty: push succeeds, pop ignored.
  - overflow clears on the first read_key_ack after it was set. If a drop and an ack occur in the same cycle, set wins.
- Reset mid-debounce or mid-scan aborts everything; no partial push.
- Top-level integration:
  - Port 06 read -> key_code.
  - Port 07 read -> {5'b0, overflow, fifo_full, key_present}.
  - read_key_ack = registered (read_strobe & port_id==06).

Decomposition:
- Shared include `keypad_defs.vh` holds:
  - KEY_CODE_W=8.
  - KEY_NONE flag encoding.
  - FSM state constants (IDLE=2'd0, CAND=2'd1, HELD=2'd2).
  - Port numbers 06/07.
- One sub-module, `key_fifo`: synchronous show-ahead FIFO parameterized by width/depth, exposing push, pop, full, empty, dout, and a drop (overflow) pulse.
- Scanner, synchronizer and FSM stay in `keypad_scanner`.

Test Plan:
Simulation parameters for all scenarios: SCAN_DIV=4, DEBOUNCE_SCANS=2, FIFO_DEPTH=4, so one scan = 16 cycles. The keypad model pulls row[r] low while col[c] is low for each pressed (c,r).
1. Release reset, no keys -> col sequence 1110,1101,1011,0111 with 4 cycles each, repeating; key_present stays 0 for 200 cycles.
2. Hold key (c=1,r=2) for 5 scans, then release -> exactly one push; key_code=8'h06, key_present=1. One ack pulse -> key_present=0 next cycle; no further push after release.
3. Bounce: key (0,0) present on alternate scans for 10 scans -> no push, FSM never reaches HELD.
4. Press (2,3) -> release for 3 scans -> press (2,3) again -> two entries 8'h0B, 8'h0B. A continuous hold of 20 scans yields a single entry.
5. Five distinct debounced presses 8'h00,8'h05,8'h0A,8'h0F,8'h01 with no ack -> fifo_full=1 after the 4th; 5th dropped, overflow=1. Four acks return 00,05,0A,0F in order; overflow=0 after the first ack.
6. Keys (3,1) and (1,0) held together -> single code 8'h04. Assert reset one scan into the CAND state of a fresh press -> outputs return to reset values and no code appears until 2 full stable scans after reset release.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// keypad_scanner_pkg
//   Shared definitions for the 4x4 keypad scanner: key code width, the
//   NONE encoding of a scan result, debounce state encoding, the
//   PicoBlaze port numbers and small helpers used by the scanner.
package keypad_scanner_pkg;

  localparam int KEY_CODE_W = 8;

  // Scan result: {none_flag, col_idx[1:0], row_idx[1:0]}
  localparam int               SCAN_KEY_W   = 5;
  localparam int               KEY_NONE_BIT = 4;
  localparam logic [SCAN_KEY_W-1:0] KEY_NONE = 5'h10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAND = 2'd1,
    HELD = 2'd2
  } deb_state_e;

  localparam logic [7:0] PORT_KEY_CODE   = 8'h06;
  localparam logic [7:0] PORT_KEY_STATUS = 8'h07;

  // Status byte presented on the status port.
  function automatic logic [7:0] key_status_byte(input logic ovf,
                                                 input logic full,
                                                 input logic present);
    return {5'b0, ovf, full, present};
  endfunction

  // First low row in the sampled column; lowest row index wins.
  function automatic logic [SCAN_KEY_W-1:0] first_low_row(input logic [3:0] row_s,
                                                          input logic [1:0] col_idx);
    logic [SCAN_KEY_W-1:0] res;
    res = KEY_NONE;
    for (int r = 3; r >= 0; r--) begin
      if (!row_s[r]) res = {1'b0, col_idx, r[1:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/keypad_scanner_key_fifo.sv
// key_fifo
//   Synchronous show-ahead FIFO. dout shows the head entry whenever the
//   FIFO is not empty and reads as zero when empty.
// Ports:
//   clk, reset    clock, synchronous active-low reset
//   push, din     write request and data
//   pop           pop head (ignored while empty)
//   dout          head entry
//   full, empty   occupancy flags
//   drop          one-cycle pulse: push refused because FIFO was full
module key_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_L);

  // A pop while full frees the slot the simultaneous push needs.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & ~do_push;

  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Autonomous 4x4 matrix keypad scanner. Drives one column low at a time,
//   samples the synchronized active-low rows at the end of each column
//   period, debounces whole-matrix scan results and queues one key code per
//   accepted press. Read side follows the UART receive convention.
// Ports:
//   clk, reset     system clock, synchronous active-low reset
//   col            column drive, one-hot-low
//   row            row sense, active-low, asynchronous
//   key_code       FIFO head {4'h0, col_idx, row_idx}, 0 when empty
//   key_present    FIFO not empty
//   read_key_ack   one-cycle pop of the FIFO head
//   fifo_full      FIFO holds FIFO_DEPTH entries
//   overflow       sticky: a press was dropped on a full FIFO
//
// Debounce FSM (advances once per completed scan):
//   state | meaning
//   IDLE  | no key accepted; waiting for any key in a scan
//   CAND  | candidate key seen in cnt consecutive scans
//   HELD  | key pushed; waiting for DEBOUNCE_SCANS scans without it
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [3:0]            col,
  input  logic [3:0]            row,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_present,
  input  logic                  read_key_ack,
  output logic                  fifo_full,
  output logic                  overflow
);

  localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam int               CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

  logic [3:0]            row_m;
  logic [3:0]            row_s;
  logic [DIV_W-1:0]      div;
  logic [1:0]            col_idx;
  logic [1:0]            col_idx_nxt;
  logic                  scan_tc;
  logic                  scan_done;
  logic [SCAN_KEY_W-1:0] scan_acc;
  logic [SCAN_KEY_W-1:0] col_hit;
  logic [SCAN_KEY_W-1:0] scan_key;
  logic                  scan_hit;

  deb_state_e            state_q, state_d;
  logic [3:0]            cand_q, cand_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      rcnt_q, rcnt_d;
  logic [CNT_W-1:0]      cnt_inc;
  logic [CNT_W-1:0]      rcnt_inc;
  logic                  push;

  logic                  fifo_empty;
  logic                  fifo_drop;

  // ---------------- column scan ----------------
  assign scan_tc     = (div == DIV_LAST);
  assign scan_done   = scan_tc && (col_idx == 2'd3);
  assign col_idx_nxt = col_idx + 2'd1;
  assign col_hit     = first_low_row(row_s, col_idx);

  // The earliest column hit of this scan is kept; otherwise this column's.
  assign scan_key = scan_acc[KEY_NONE_BIT] ? col_hit : scan_acc;
  assign scan_hit = ~scan_key[KEY_NONE_BIT];

  always_ff @(posedge clk) begin
    if (!reset) begin
      row_m    <= 4'hF;
      row_s    <= 4'hF;
      div      <= '0;
      col_idx  <= 2'd0;
      col      <= 4'b1110;
      scan_acc <= KEY_NONE;
    end else begin
      row_m <= row;
      row_s <= row_m;
      if (scan_tc) begin
        div      <= '0;
        col_idx  <= col_idx_nxt;
        col      <= ~(4'b0001 << col_idx_nxt);
        scan_acc <= scan_done ? KEY_NONE : scan_key;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  // ---------------- debounce FSM ----------------
  assign cnt_inc  = cnt_q + 1'b1;
  assign rcnt_inc = rcnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cand_q  <= 4'h0;
      cnt_q   <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    push    = 1'b0;
    if (scan_done) begin
      case (state_q)
        IDLE: begin
          if (scan_hit) begin
            cand_d = scan_key[3:0];
            cnt_d  = CNT_W'(1);
            if (DEBOUNCE_SCANS == 1) begin
              push    = 1'b1;
              rcnt_d  = '0;
              state_d = HELD;
            end else begin
              state_d = CAND;
            end
          end
        end
        CAND: begin
          if (scan_hit && (scan_key[3:0] == cand_q)) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              push    = 1'b1;
              rcnt_d  = '0;
              state_d = HELD;
            end
          end else if (scan_hit) begin
            cand_d = scan_key[3:0];
            cnt_d  = CNT_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          // Any other result, including a different key, counts toward release.
          if (scan_hit && (scan_key[3:0] == cand_q)) begin
            rcnt_d = '0;
          end else if (rcnt_inc == CNT_DONE) begin
            rcnt_d  = '0;
            state_d = IDLE;
          end else begin
            rcnt_d = rcnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------- key FIFO ----------------
  // The pushed code always equals the current scan winner.
  key_fifo #(
    .WIDTH(KEY_CODE_W),
    .DEPTH(FIFO_DEPTH)
  ) u_key_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   ({4'h0, scan_key[3:0]}),
    .pop   (read_key_ack),
    .dout  (key_code),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  assign key_present = ~fifo_empty;

  // A drop in the same cycle as an ack keeps the flag set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (fifo_drop) begin
      overflow <= 1'b1;
    end else if (read_key_ack) begin
      overflow <= 1'b0;
    end
  end

endmodule
